baby_kyber_matvec_ctrl: RTL and testbench

- Sequences the shared 4-coefficient polynomial multiplier (Z_17[x]/(x^4+1)) to compute the Baby Kyber product t = A*s + e, where A is a KxK polynomial matrix and s and e are K-polynomial vectors.
- Latches operands on a start handshake and issues one multiplier operation per cycle.
- Accumulates the registered products mod Q per row and presents t with a done pulse.
- Sits between the key-generation/encryption control and the multiplier instance.

---
 rtl/baby_kyber_matvec_ctrl.sv | 111 +++++++++++
 tb/tb_baby_kyber_matvec_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/baby_kyber_matvec_ctrl.sv
// baby_kyber_matvec_ctrl: sequences a shared negacyclic polynomial multiplier to compute t = A*s + e mod Q.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, abort       job request (taken when idle) and synchronous cancel of a running job
//   mat_in/vec_s/vec_e operands A (K*K polys), s and e (K polys each), N coefficients of W bits per poly
//   busy, done         job in progress, one-cycle completion pulse
//   res_out            result t, held until the next completed job
//   mul_en/mul_a/mul_b multiplier request, operands forced to 0 when idle
//   mul_res            multiplier product, registered one cycle after mul_en
module baby_kyber_matvec_ctrl #(
    parameter int K = 2,
    parameter int N = 4,
    parameter int W = 32,
    parameter int Q = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [K*K*N*W-1:0]   mat_in,
    input  logic [K*N*W-1:0]     vec_s,
    input  logic [K*N*W-1:0]     vec_e,
    output logic                 busy,
    output logic                 done,
    output logic [K*N*W-1:0]     res_out,
    output logic                 mul_en,
    output logic [N*W-1:0]       mul_a,
    output logic [N*W-1:0]       mul_b,
    input  logic [N*W-1:0]       mul_res
);
    localparam int PW = N * W;
    localparam int KK = K * K;
    localparam int IW = KK > 1 ? $clog2(KK) : 1;
    localparam int TW = K > 1 ? $clog2(K) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t            state_q, state_d;
    logic [KK*PW-1:0]  a_q, a_d;
    logic [K*PW-1:0]   s_q, s_d, acc_q, acc_d, res_q, res_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [TW-1:0]     tag_q, tag_d;
    logic              mul_v_q, mul_v_d, done_q, done_d;
    logic [W-1:0]      sum [N];
    assign busy    = state_q != IDLE;
    assign mul_en  = state_q == RUN;
    assign mul_a   = mul_en ? a_q[int'(idx_q)*PW +: PW] : '0;
    assign mul_b   = mul_en ? s_q[(int'(idx_q) % K)*PW +: PW] : '0;
    assign done    = done_q;
    assign res_out = res_q;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        s_d     = s_q;
        acc_d   = acc_q;
        res_d   = res_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        mul_v_d = 1'b0;
        done_d  = 1'b0;
        // mul_v_q marks a product issued last cycle; tag_q is the row it belongs to
        for (int c = 0; c < N; c++) begin
            sum[c] = acc_q[(int'(tag_q)*N+c)*W +: W] + mul_res[c*W +: W];
            acc_d[(int'(tag_q)*N+c)*W +: W] = !mul_v_q ? acc_q[(int'(tag_q)*N+c)*W +: W] :
                                              sum[c] >= W'(Q) ? sum[c] - W'(Q) : sum[c];
        end
        case (state_q)
            IDLE: if (start) begin
                a_d     = mat_in;
                s_d     = vec_s;
                acc_d   = vec_e;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                mul_v_d = !abort;
                tag_d   = TW'(int'(idx_q) / K);
                idx_d   = idx_q + 1'b1;
                state_d = abort ? IDLE : idx_q == IW'(KK-1) ? DRAIN : RUN;
            end
            DRAIN: begin
                // acc_d already holds the final accumulate of the last product
                res_d   = abort ? res_q : acc_d;
                done_d  = !abort;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            s_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            mul_v_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            s_q     <= s_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            mul_v_q <= mul_v_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_baby_kyber_matvec_ctrl.sv
// tb_baby_kyber_matvec_ctrl: directed table, corner-case sequences and random jobs against a reference model.
module tb_baby_kyber_matvec_ctrl;
    localparam int K = 2, N = 4, W = 32, Q = 17;
    localparam int PW = N * W, VW = K * PW, MW = K * K * PW;
    localparam logic [PW-1:0] Z = '0;
    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [MW-1:0] mat_in = '0;
    logic [VW-1:0] vec_s = '0, vec_e = '0;
    logic          busy, done, mul_en;
    logic [VW-1:0] res_out;
    logic [PW-1:0] mul_a, mul_b, mul_res;
    int errors = 0, checks = 0;
    typedef struct {
        string         name;
        logic [MW-1:0] m;
        logic [VW-1:0] s, e, exp;
    } vec_t;
    vec_t tv [4];
    always #5 clk = ~clk;
    baby_kyber_matvec_ctrl #(.K(K), .N(N), .W(W), .Q(Q)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .mat_in(mat_in), .vec_s(vec_s), .vec_e(vec_e),
        .busy(busy), .done(done), .res_out(res_out),
        .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res)
    );
    function automatic logic [PW-1:0] p4(input int c0, input int c1, input int c2, input int c3);
        return {W'(c3), W'(c2), W'(c1), W'(c0)};
    endfunction
    function automatic logic [PW-1:0] polymul(input logic [PW-1:0] a, input logic [PW-1:0] b);
        int t [N];
        logic [PW-1:0] r;
        for (int i = 0; i < N; i++) t[i] = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int p;
                p = int'(a[i*W +: W]) * int'(b[j*W +: W]);
                if (i + j < N) t[i+j] += p;
                else t[i+j-N] -= p;
            end
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(((t[i] % Q) + Q) % Q);
        return r;
    endfunction
    function automatic logic [VW-1:0] ref_mv(input logic [MW-1:0] m, input logic [VW-1:0] s, input logic [VW-1:0] e);
        logic [VW-1:0] r;
        logic [PW-1:0] p;
        r = e;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) begin
                p = polymul(m[(i*K+j)*PW +: PW], s[j*PW +: PW]);
                for (int c = 0; c < N; c++)
                    r[(i*N+c)*W +: W] = W'((int'(r[(i*N+c)*W +: W]) + int'(p[c*W +: W])) % Q);
            end
        return r;
    endfunction
    // behavioural stand-in for the registered multiplier
    always_ff @(posedge clk) if (mul_en) mul_res <= polymul(mul_a, mul_b);
    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    // start at cycle T, then watch timing, multiplier traffic and the result
    task automatic run_job(input string name, input logic [MW-1:0] m, input logic [VW-1:0] s,
                           input logic [VW-1:0] e, input logic [VW-1:0] exp);
        int done_at = 0, en_cnt = 0, bad = 0;
        @(posedge clk); #1;
        mat_in = m; vec_s = s; vec_e = e; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; mat_in = '0; vec_s = '0; vec_e = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mul_en) begin
                en_cnt++;
                if (k > K*K || mul_a !== m[(k-1)*PW +: PW] || mul_b !== s[((k-1)%K)*PW +: PW]) bad++;
            end else if (mul_a !== '0 || mul_b !== '0) bad++;
            if (busy !== (k <= K*K+1)) bad++;
            if (done) begin
                done_at = k;
                break;
            end
            @(posedge clk); #1;
        end
        chki({name, " done cycle"}, done_at, K*K+2);
        chki({name, " mul_en cycles"}, en_cnt, K*K);
        chki({name, " operand/busy errors"}, bad, 0);
        chk({name, " res_out"}, res_out, exp);
    endtask
    initial begin
        tv[0] = '{name: "identity", m: {Z, Z, Z, p4(1,0,0,0)}, s: {Z, p4(1,2,3,4)},
                  e: '0, exp: {Z, p4(1,2,3,4)}};
        tv[1] = '{name: "wrap", m: {p4(0,1,0,0), Z, Z, Z}, s: {p4(0,0,0,1), Z},
                  e: '0, exp: {p4(16,0,0,0), Z}};
        tv[2] = '{name: "modacc", m: {Z, Z, p4(1,0,0,0), p4(1,0,0,0)}, s: {p4(1,1,1,1), p4(16,16,16,16)},
                  e: {Z, p4(16,0,0,0)}, exp: {Z, p4(16,0,0,0)}};
        tv[3] = '{name: "x3x2", m: {Z, Z, p4(0,0,0,2), Z}, s: {p4(0,0,3,0), Z},
                  e: {p4(5,5,5,5), Z}, exp: {p4(5,5,5,5), p4(0,11,0,0)}};
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chki("reset busy", int'(busy), 0);
        chki("reset done", int'(done), 0);
        chki("reset mul_en", int'(mul_en), 0);
        chk("reset mul_a/mul_b", {mul_a, mul_b}, '0);
        chk("reset res_out", res_out, '0);
        for (int i = 0; i < 4; i++) run_job(tv[i].name, tv[i].m, tv[i].s, tv[i].e, tv[i].exp);
        abort = 1'b1;
        run_job("start+abort idle", tv[2].m, tv[2].s, tv[2].e, tv[2].exp);
        begin : b2b
            int dcnt = 0, d1 = 0, d2 = 0;
            for (int k = 0; k <= 14; k++) begin
                @(posedge clk); #1;
                start = (k == 0 || k == 3 || k == 6);
                if (k == 0) {mat_in, vec_s, vec_e} = {tv[0].m, tv[0].s, tv[0].e};
                if (k == 3) {mat_in, vec_s, vec_e} = {tv[1].m, tv[1].s, tv[1].e};
                @(negedge clk);
                if (done) begin
                    dcnt++;
                    if (dcnt == 1) begin
                        d1 = k;
                        chk("b2b first res_out", res_out, tv[0].exp);
                    end else begin
                        d2 = k;
                        chk("b2b second res_out", res_out, tv[1].exp);
                    end
                end
            end
            start = 1'b0;
            chki("b2b done count", dcnt, 2);
            chki("b2b first done cycle", d1, 6);
            chki("b2b second done cycle", d2, 12);
        end
        run_job("pre-abort identity", tv[0].m, tv[0].s, tv[0].e, tv[0].exp);
        begin : abort_seq
            int saw = 0, bad = 0;
            for (int k = 0; k <= 10; k++) begin
                @(posedge clk); #1;
                start = (k == 0);
                abort = (k == 2);
                if (k == 0) {mat_in, vec_s, vec_e} = {tv[1].m, tv[1].s, tv[1].e};
                @(negedge clk);
                if (done) saw++;
                if (k >= 1 && k <= 2 && !busy) bad++;
                if (k >= 3 && (busy || mul_en || mul_a !== '0 || mul_b !== '0)) bad++;
            end
            chki("abort done pulses", saw, 0);
            chki("abort busy/mul_en errors", bad, 0);
            chk("abort res_out held", res_out, tv[0].exp);
        end
        begin : reset_seq
            int saw = 0;
            @(posedge clk); #1;
            start = 1'b1;
            {mat_in, vec_s, vec_e} = {tv[1].m, tv[1].s, tv[1].e};
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            chki("busy before reset", int'(busy), 1);
            rst_n = 1'b0;
            #1;
            chki("midjob reset busy", int'(busy), 0);
            chki("midjob reset done", int'(done), 0);
            chki("midjob reset mul_en", int'(mul_en), 0);
            chk("midjob reset mul_a/mul_b", {mul_a, mul_b}, '0);
            chk("midjob reset res_out", res_out, '0);
            #20;
            rst_n = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (done || busy) saw++;
            end
            chki("after reset activity", saw, 0);
        end
        for (int n = 0; n < 200; n++) begin
            logic [MW-1:0] m;
            logic [VW-1:0] s, e;
            for (int i = 0; i < K*K*N; i++) m[i*W +: W] = W'($urandom_range(0, Q-1));
            for (int i = 0; i < K*N; i++) begin
                s[i*W +: W] = W'($urandom_range(0, Q-1));
                e[i*W +: W] = W'($urandom_range(0, Q-1));
            end
            run_job("random", m, s, e, ref_mv(m, s, e));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
